// File: rtl/game_round_ctrl.sv
// Game-flow controller: IDLE -> PLAY -> OVER -> IDLE with pause,
// lives counter and a built-in one-second prescaler.
module game_round_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int ROUND_SECS = 60,
  parameter int OVER_SECS  = 5,
  parameter int LIVES      = 3,
  parameter int TIMER_W    = 8,
  parameter int LIFE_W     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               end_btn,
  input  logic               life_lost,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] secs_left,
  output logic [LIFE_W-1:0]  lives,
  output logic               sec_tick,
  output logic               round_end
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAY  = 3'd1;
  localparam logic [2:0] S_OVER  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd4;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0] PRE_TOP =
    PW'(CLK_HZ - 1);
  localparam logic [TIMER_W-1:0] ROUND_V =
    TIMER_W'(ROUND_SECS);
  localparam logic [TIMER_W-1:0] OVER_V =
    TIMER_W'(OVER_SECS);
  localparam logic [LIFE_W-1:0] LIVES_V =
    LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] LIFE_ONE =
    LIFE_W'(1);
  localparam logic [TIMER_W-1:0] SEC_ONE =
    TIMER_W'(1);

  logic               r_start_q;
  logic               r_pause_q;
  logic               r_end_q;
  logic [2:0]         r_state;
  logic [PW-1:0]      r_pre;
  logic [TIMER_W-1:0] r_secs;
  logic [LIFE_W-1:0]  r_lives;
  logic               r_round_end;

  logic [2:0] w_next;
  logic       w_start_e;
  logic       w_pause_e;
  logic       w_end_e;
  logic       w_run;
  logic       w_tick;
  logic       w_life_out;
  logic       w_time_out;
  logic       w_play_upd;
  logic       w_new_round;
  logic       w_enter_over;

  // Edge registers park at 1 so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q <= 1'b1;
      r_pause_q <= 1'b1;
      r_end_q   <= 1'b1;
    end else begin
      r_start_q <= start_btn;
      r_pause_q <= pause_btn;
      r_end_q   <= end_btn;
    end
  end

  always_comb begin
    w_start_e  = start_btn & ~r_start_q;
    w_pause_e  = pause_btn & ~r_pause_q;
    w_end_e    = end_btn & ~r_end_q;
    w_run      = (r_state == S_PLAY) ||
                 (r_state == S_OVER);
    w_tick     = w_run && (r_pre == PRE_TOP);
    w_life_out = life_lost && (r_lives <= LIFE_ONE);
    w_time_out = w_tick && (r_secs <= SEC_ONE);
    w_play_upd = (r_state == S_PLAY) &&
                 !w_end_e && !w_pause_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_e) begin
          w_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (w_end_e) begin
          w_next = S_OVER;
        end else if (w_pause_e) begin
          w_next = S_PAUSE;
        end else if (w_life_out || w_time_out) begin
          w_next = S_OVER;
        end
      end
      S_PAUSE: begin
        if (w_end_e) begin
          w_next = S_OVER;
        end else if (w_start_e || w_pause_e) begin
          w_next = S_PLAY;
        end
      end
      S_OVER: begin
        if (w_time_out) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_new_round  = (r_state == S_IDLE) &&
                   (w_next == S_PLAY);
    w_enter_over = (w_next == S_OVER) &&
                   (r_state != S_OVER);
  end

  // Prescaler, countdown and lives; PAUSE freezes all three.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre       <= '0;
      r_secs      <= '0;
      r_lives     <= LIVES_V;
      r_round_end <= 1'b0;
    end else begin
      r_round_end <= w_enter_over;

      if (w_enter_over || w_new_round) begin
        r_pre <= '0;
      end else if (w_run) begin
        r_pre <= w_tick ? '0 : r_pre + PW'(1);
      end

      if (w_new_round) begin
        r_secs  <= ROUND_V;
        r_lives <= LIVES_V;
      end else begin
        if (w_play_upd && life_lost &&
            (r_lives != '0)) begin
          r_lives <= r_lives - LIFE_ONE;
        end
        if (w_enter_over) begin
          r_secs <= OVER_V;
        end else if (w_next == S_IDLE) begin
          r_secs <= '0;
        end else if (w_tick && (r_secs != '0) &&
                     (w_play_upd ||
                      r_state == S_OVER)) begin
          r_secs <= r_secs - SEC_ONE;
        end
      end
    end
  end

  always_comb begin
    state     = r_state;
    secs_left = (r_state == S_IDLE) ? '0 : r_secs;
    lives     = r_lives;
    sec_tick  = w_tick;
    round_end = r_round_end;
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_game_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       pause_btn;
  logic       end_btn;
  logic       life_lost;
  logic [2:0] state;
  logic [7:0] secs_left;
  logic [2:0] lives;
  logic       sec_tick;
  logic       round_end;

  game_round_ctrl #(
    .CLK_HZ    (4),
    .ROUND_SECS(3),
    .OVER_SECS (2),
    .LIVES     (2),
    .TIMER_W   (8),
    .LIFE_W    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .end_btn  (end_btn),
    .life_lost(life_lost),
    .state    (state),
    .secs_left(secs_left),
    .lives    (lives),
    .sec_tick (sec_tick),
    .round_end(round_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    string nm;
    int    st;
    int    sl;
    int    lv;
    int    tk;
    int    re;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic ex(input int base, input int k,
                    input string nm, input int st,
                    input int sl, input int lv,
                    input int tk, input int re);
    exp_t e;
    e.at = base + k;
    e.nm = nm;
    e.st = st;
    e.sl = sl;
    e.lv = lv;
    e.tk = tk;
    e.re = re;
    sb.push_back(e);
  endtask

  task automatic till(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checks++;
        if ({state, secs_left, lives, sec_tick,
             round_end} !==
            {3'(sb[i].st), 8'(sb[i].sl),
             3'(sb[i].lv), 1'(sb[i].tk),
             1'(sb[i].re)}) begin
          errors++;
          $display("FAIL %s cyc=%0d got st=%0d sl=%0d lv=%0d tk=%0b re=%0b want st=%0d sl=%0d lv=%0d tk=%0d re=%0d",
                   sb[i].nm, cyc, state, secs_left,
                   lives, sec_tick, round_end,
                   sb[i].st, sb[i].sl, sb[i].lv,
                   sb[i].tk, sb[i].re);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  int b;

  initial begin
    rst = 1'b1;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    end_btn = 1'b0;
    life_lost = 1'b0;
    till(2);
    rst = 1'b0;
    b = cyc;
    ex(b, 0, "reset", 0, 0, 2, 0, 0);

    // full round by timeout, start held throughout
    till(b + 2);
    b = cyc;
    start_btn = 1'b1;
    ex(b, 1,  "t1_play",    1, 3, 2, 0, 0);
    ex(b, 4,  "t1_tick1",   1, 3, 2, 1, 0);
    ex(b, 5,  "t1_sec2",    1, 2, 2, 0, 0);
    ex(b, 12, "t1_last",    1, 1, 2, 1, 0);
    ex(b, 13, "t1_over",    2, 2, 2, 0, 1);
    ex(b, 14, "t1_re_once", 2, 2, 2, 0, 0);
    ex(b, 16, "t1_otick1",  2, 2, 2, 1, 0);
    ex(b, 20, "t1_otick2",  2, 1, 2, 1, 0);
    ex(b, 21, "t1_idle",    0, 0, 2, 0, 0);
    ex(b, 23, "t1_held",    0, 0, 2, 0, 0);
    till(b + 23);
    start_btn = 1'b0;

    // pause/resume mid-second, then two lives lost
    till(b + 25);
    b = cyc;
    start_btn = 1'b1;
    ex(b, 1,  "t2_play",     1, 3, 2, 0, 0);
    ex(b, 6,  "t2_pre1",     1, 2, 2, 0, 0);
    ex(b, 7,  "t2_pause",    4, 2, 2, 0, 0);
    ex(b, 16, "t2_held",     4, 2, 2, 0, 0);
    ex(b, 17, "t2_release",  4, 2, 2, 0, 0);
    ex(b, 18, "t2_resume",   1, 2, 2, 0, 0);
    ex(b, 19, "t2_tick",     1, 2, 2, 1, 0);
    ex(b, 20, "t2_sec1",     1, 1, 2, 0, 0);
    ex(b, 21, "t3_ll1",      1, 1, 1, 0, 0);
    ex(b, 22, "t3_between",  1, 1, 1, 0, 0);
    ex(b, 23, "t3_over",     2, 2, 0, 0, 1);
    ex(b, 24, "t3_re_once",  2, 2, 0, 0, 0);
    ex(b, 26, "t3_otick",    2, 2, 0, 1, 0);
    ex(b, 30, "t3_otick2",   2, 1, 0, 1, 0);
    ex(b, 31, "t3_idle",     0, 0, 0, 0, 0);
    ex(b, 33, "t3_ll_idle",  0, 0, 0, 0, 0);
    till(b + 1);
    start_btn = 1'b0;
    till(b + 6);
    pause_btn = 1'b1;
    till(b + 16);
    pause_btn = 1'b0;
    till(b + 17);
    start_btn = 1'b1;
    till(b + 18);
    start_btn = 1'b0;
    till(b + 20);
    life_lost = 1'b1;
    till(b + 21);
    life_lost = 1'b0;
    till(b + 22);
    life_lost = 1'b1;
    till(b + 23);
    life_lost = 1'b0;
    till(b + 32);
    life_lost = 1'b1;
    till(b + 33);
    life_lost = 1'b0;

    // life lost together with the final second
    till(b + 35);
    b = cyc;
    start_btn = 1'b1;
    ex(b, 1,  "t4_play",    1, 3, 2, 0, 0);
    ex(b, 12, "t4_last",    1, 1, 2, 1, 0);
    ex(b, 13, "t4_over",    2, 2, 1, 0, 1);
    ex(b, 14, "t4_re_once", 2, 2, 1, 0, 0);
    ex(b, 21, "t4_idle",    0, 0, 1, 0, 0);
    till(b + 1);
    start_btn = 1'b0;
    till(b + 12);
    life_lost = 1'b1;
    till(b + 13);
    life_lost = 1'b0;

    // end beats pause in the same cycle
    till(b + 23);
    b = cyc;
    start_btn = 1'b1;
    ex(b, 1,  "t5_play",     1, 3, 2, 0, 0);
    ex(b, 3,  "t5_end_wins", 2, 2, 2, 0, 1);
    ex(b, 11, "t5_idle",     0, 0, 2, 0, 0);
    till(b + 1);
    start_btn = 1'b0;
    till(b + 2);
    end_btn = 1'b1;
    pause_btn = 1'b1;
    till(b + 4);
    end_btn = 1'b0;
    pause_btn = 1'b0;

    // start held through reset, then reset during OVER
    till(b + 13);
    b = cyc;
    start_btn = 1'b1;
    rst = 1'b1;
    ex(b, 1,  "t5_rst",       0, 0, 2, 0, 0);
    ex(b, 2,  "t5_held_a",    0, 0, 2, 0, 0);
    ex(b, 3,  "t5_held_b",    0, 0, 2, 0, 0);
    ex(b, 5,  "t5_one_start", 1, 3, 2, 0, 0);
    ex(b, 10, "t5_still",     1, 2, 1, 0, 0);
    ex(b, 11, "t6_over",      2, 2, 1, 0, 1);
    ex(b, 15, "t6_over_s1",   2, 1, 1, 0, 0);
    ex(b, 16, "t6_rst",       0, 0, 2, 0, 0);
    ex(b, 18, "t6_idle",      0, 0, 2, 0, 0);
    till(b + 1);
    rst = 1'b0;
    till(b + 3);
    start_btn = 1'b0;
    till(b + 4);
    start_btn = 1'b1;
    till(b + 9);
    life_lost = 1'b1;
    till(b + 10);
    life_lost = 1'b0;
    start_btn = 1'b0;
    end_btn = 1'b1;
    till(b + 11);
    end_btn = 1'b0;
    till(b + 15);
    rst = 1'b1;
    till(b + 16);
    rst = 1'b0;
    till(b + 20);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d pending want 0",
               sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
